// File: rtl/bus_grant_lock.sv
// rtl/bus_grant_lock.sv - round-robin bus arbiter that locks a one-hot grant until transfer done or hold timeout
module bus_grant_lock #(
    parameter int N_MASTERS = 4,
    parameter int MAX_HOLD  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_MASTERS-1:0]         req,
    input  logic                         xfer_done,
    output logic [N_MASTERS-1:0]         grant,
    output logic                         grant_valid,
    output logic [$clog2(N_MASTERS)-1:0] grant_idx,
    output logic                         timeout_err
);

    localparam int W_IDX  = $clog2(N_MASTERS);
    localparam int W_HOLD = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [W_IDX-1:0]  LAST_IDX  = W_IDX'(N_MASTERS - 1);
    localparam logic [W_HOLD-1:0] HOLD_LAST = W_HOLD'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [W_HOLD-1:0] HOLD_SAT  = {W_HOLD{1'b1}};

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]           state;
    logic [W_IDX-1:0]     rr_ptr;
    logic [W_HOLD-1:0]    hold_cnt;

    logic                 win_found;
    logic [W_IDX-1:0]     win_idx;
    logic [W_IDX-1:0]     cand_idx;
    logic [N_MASTERS-1:0] win_onehot;
    logic [W_IDX-1:0]     next_ptr;
    int                   cand;

    logic                 owner_req;
    logic                 timeout_hit;
    logic                 release_now;

    // Scan masters starting at rr_ptr; the first requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_MASTERS) begin
                cand = cand - N_MASTERS;
            end
            cand_idx = W_IDX'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_onehot = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
        next_ptr   = (win_idx == LAST_IDX) ? '0 : (win_idx + 1'b1);
    end

    // Release priority: done, then abandoned request, then hold timeout.
    always_comb begin
        owner_req   = req[grant_idx];
        timeout_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        release_now = xfer_done || !owner_req || timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state       <= ST_OWNED;
                        grant       <= win_onehot;
                        grant_valid <= 1'b1;
                        grant_idx   <= win_idx;
                        rr_ptr      <= next_ptr;
                        hold_cnt    <= '0;
                    end
                end
                ST_OWNED: begin
                    if (release_now) begin
                        state       <= ST_IDLE;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_idx   <= '0;
                        hold_cnt    <= '0;
                        timeout_err <= !xfer_done && owner_req;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    grant_idx   <= '0;
                    hold_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_grant_lock.sv
// tb/tb_bus_grant_lock.sv - directed and random checks of bus_grant_lock against an ownership model
module tb_bus_grant_lock;

    localparam int N  = 4;
    localparam int MH = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         xfer_done;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         timeout_err;

    int n_tests;
    int n_fail;

    // Model: who owns the bus, whose turn is next, how long the owner has held it.
    int m_owner;
    int m_next;
    int m_age;
    bit m_to;

    bus_grant_lock #(.N_MASTERS(N), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .xfer_done   (xfer_done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_next  = 0;
        m_age   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic d);
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_next + k) % N;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_next  = (c + 1) % N;
                    m_age   = 1;
                end
            end
        end else if (d) begin
            m_owner = -1;
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (m_age >= MH) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_age = m_age + 1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        logic [1:0]   ei;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ei = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        n_tests++;
        assert (grant === eg) else begin
            n_fail++;
            $error("FAIL %s grant got %b exp %b", tag, grant, eg);
        end
        n_tests++;
        assert (grant_valid === (m_owner >= 0)) else begin
            n_fail++;
            $error("FAIL %s grant_valid got %b exp %b", tag, grant_valid, (m_owner >= 0));
        end
        n_tests++;
        assert (grant_idx === ei) else begin
            n_fail++;
            $error("FAIL %s grant_idx got %0d exp %0d", tag, grant_idx, ei);
        end
        n_tests++;
        assert (timeout_err === m_to) else begin
            n_fail++;
            $error("FAIL %s timeout_err got %b exp %b", tag, timeout_err, m_to);
        end
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] eg, input logic eto);
        n_tests++;
        assert (grant === eg && timeout_err === eto) else begin
            n_fail++;
            $error("FAIL %s grant/timeout got %b/%b exp %b/%b", tag, grant, timeout_err, eg, eto);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic d, input string tag);
        req       = r;
        xfer_done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        xfer_done = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rr;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = '0;
        xfer_done = 1'b0;
        model_reset();
        #12;
        check_model("reset_init");
        rst_n = 1'b1;

        // 1: single master, done three cycles after grant
        step(4'b0001, 1'b0, "t1_grant");
        expect_out("t1_grant", 4'b0001, 1'b0);
        step(4'b0001, 1'b0, "t1_hold");
        step(4'b0001, 1'b0, "t1_hold");
        step(4'b0001, 1'b1, "t1_done");
        expect_out("t1_release", 4'b0000, 1'b0);
        step(4'b0000, 1'b0, "t1_idle");

        // 2: all request, rotation order with an idle cycle between owners
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 1'b0, "t2_grant");
            expect_out("t2_order", 4'(1 << (k % 4)), 1'b0);
            step(4'b1111, 1'b1, "t2_done");
            expect_out("t2_gap", 4'b0000, 1'b0);
        end

        // 3: winner drops to lowest priority
        do_reset();
        step(4'b0101, 1'b0, "t3_g0");
        expect_out("t3_first", 4'b0001, 1'b0);
        step(4'b0101, 1'b1, "t3_d0");
        step(4'b0101, 1'b0, "t3_g2");
        expect_out("t3_second", 4'b0100, 1'b0);
        step(4'b0101, 1'b1, "t3_d2");
        step(4'b0001, 1'b0, "t3_g0b");
        expect_out("t3_third", 4'b0001, 1'b0);
        step(4'b0001, 1'b1, "t3_d0b");

        // 4: hold timeout after exactly 16 granted cycles, then regrant
        step(4'b0010, 1'b0, "t4_grant");
        expect_out("t4_grant", 4'b0010, 1'b0);
        for (int k = 0; k < 15; k++) begin
            step(4'b0010, 1'b0, "t4_hold");
            expect_out("t4_held", 4'b0010, 1'b0);
        end
        step(4'b0010, 1'b0, "t4_timeout");
        expect_out("t4_timeout", 4'b0000, 1'b1);
        step(4'b0010, 1'b0, "t4_regrant");
        expect_out("t4_regrant", 4'b0010, 1'b0);
        step(4'b0010, 1'b1, "t4_done");

        // 5: done coincides with timeout; owner abandons; done while idle
        step(4'b0000, 1'b0, "t5_idle");
        step(4'b1000, 1'b0, "t5_grant");
        expect_out("t5_grant", 4'b1000, 1'b0);
        for (int k = 0; k < 15; k++) step(4'b1000, 1'b0, "t5_hold");
        step(4'b1000, 1'b1, "t5_done_wins");
        expect_out("t5_done_wins", 4'b0000, 1'b0);
        step(4'b0000, 1'b0, "t5_idle2");
        step(4'b0100, 1'b0, "t5_g2");
        step(4'b0100, 1'b0, "t5_h2");
        step(4'b0000, 1'b0, "t5_abandon");
        expect_out("t5_abandon", 4'b0000, 1'b0);
        step(4'b0000, 1'b1, "t5_done_idle");
        expect_out("t5_done_idle", 4'b0000, 1'b0);

        // 6: asynchronous reset while owned
        step(4'b1111, 1'b0, "t6_grant");
        step(4'b1111, 1'b0, "t6_hold");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("t6_async");
        expect_out("t6_async", 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        check_model("t6_in_reset");
        rst_n = 1'b1;
        step(4'b1111, 1'b0, "t6_after");
        expect_out("t6_after", 4'b0001, 1'b0);
        step(4'b1111, 1'b1, "t6_done");

        // random traffic
        rr = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
            step(rr, ($urandom_range(0, 9) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
